// File: rtl/ram_dp_ctrl.sv
// Simple dual-port RAM: one write port with lane enables, one read port,
// selectable read-during-write policy, optional output register, zero-fill sequencer.
module ram_dp_ctrl #(
  parameter int unsigned mem_depth = 32,
  parameter int unsigned size      = 32,
  parameter int unsigned lane      = 8,
  parameter int unsigned bypass    = 0,
  parameter int unsigned out_reg   = 0,
  localparam int unsigned NL = size / lane,
  localparam int unsigned AW = $clog2(mem_depth)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [size-1:0] data_in,
  input  logic            wren,
  input  logic [NL-1:0]   be,
  input  logic [AW-1:0]   wraddress,
  input  logic            rden,
  input  logic [AW-1:0]   rdaddress,
  input  logic            clear,
  output logic [size-1:0] data_out,
  output logic            rd_valid,
  output logic            busy
);

  typedef enum logic {INIT, READY} state_e;

  localparam logic [AW:0]   DEPTH = (AW+1)'(mem_depth);
  localparam logic [AW-1:0] LAST  = AW'(mem_depth - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [size-1:0] mem_q [mem_depth];

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [size-1:0] mem_wdata;
  logic [NL-1:0]   mem_be;
  logic            wr_fire;
  logic            rd_fire;
  logic            wr_in_range;
  logic            rd_in_range;
  logic [size-1:0] rd_word;

  logic            st_valid;
  logic [size-1:0] st_data;
  logic            rd_valid_q, rd_valid_d;
  logic [size-1:0] data_out_q, data_out_d;

  assign wr_in_range = {1'b0, wraddress} < DEPTH;
  assign rd_in_range = {1'b0, rdaddress} < DEPTH;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_addr  = wraddress;
    mem_wdata = data_in;
    mem_be    = be;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        mem_be    = '1;
        if (ptr_q == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_d = INIT;
          ptr_d   = '0;
        end else begin
          wr_fire = wren && wr_in_range;
          mem_we  = wr_fire;
          rd_fire = rden;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Read word, with lane-wise merge of the concurrent write when bypassing.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rdaddress];
    end
    if (bypass != 0 && wr_fire && wraddress == rdaddress) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (be[i]) begin
          rd_word[i*lane +: lane] = data_in[i*lane +: lane];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][i*lane +: lane] <= mem_wdata[i*lane +: lane];
        end
      end
    end
  end

  generate
    if (out_reg != 0) begin : g_pipe
      logic            pipe_valid_q, pipe_valid_d;
      logic [size-1:0] pipe_data_q, pipe_data_d;

      always_comb begin
        pipe_valid_d = rd_fire;
        pipe_data_d  = rd_fire ? rd_word : pipe_data_q;
      end

      // Not flushed by clear: an in-flight read still completes.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          pipe_valid_q <= 1'b0;
          pipe_data_q  <= '0;
        end else begin
          pipe_valid_q <= pipe_valid_d;
          pipe_data_q  <= pipe_data_d;
        end
      end

      assign st_valid = pipe_valid_q;
      assign st_data  = pipe_data_q;
    end else begin : g_nopipe
      assign st_valid = rd_fire;
      assign st_data  = rd_word;
    end
  endgenerate

  always_comb begin
    rd_valid_d = st_valid;
    data_out_d = st_valid ? st_data : data_out_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_ram_dp_ctrl.sv
// Directed bench: u0 is the old-data / single-latency build, u1 the bypass / registered-output build.
module tb_ram_dp_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_in;
  logic        wren;
  logic [3:0]  be;
  logic [4:0]  wraddress;
  logic        rden;
  logic [4:0]  rdaddress;
  logic        clear;
  logic [31:0] dout0, dout1;
  logic        v0, v1, busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  ram_dp_ctrl #(.mem_depth(32), .size(32), .lane(8), .bypass(0), .out_reg(0)) u0 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .wren(wren), .be(be),
    .wraddress(wraddress), .rden(rden), .rdaddress(rdaddress), .clear(clear),
    .data_out(dout0), .rd_valid(v0), .busy(busy0)
  );

  ram_dp_ctrl #(.mem_depth(32), .size(32), .lane(8), .bypass(1), .out_reg(1)) u1 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .wren(wren), .be(be),
    .wraddress(wraddress), .rden(rden), .rdaddress(rdaddress), .clear(clear),
    .data_out(dout1), .rd_valid(v1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        wren;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rden;
    logic [4:0]  ra;
    logic [31:0] e0d;
    logic        e0v;
    logic [31:0] e1d;
    logic        e1v;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wren = 1'b0; rden = 1'b0; clear = 1'b0; be = '0;
    wraddress = '0; rdaddress = '0; data_in = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout0"}, dout0, 32'h0);
    chk({tag, "_dout1"}, dout1, 32'h0);
    chk({tag, "_valid0"}, 32'(v0), 32'h0);
    chk({tag, "_valid1"}, 32'(v1), 32'h0);
    chk({tag, "_busy0"}, 32'(busy0), 32'h1);
    chk({tag, "_busy1"}, 32'(busy1), 32'h1);
  endtask

  // Counts edges until busy drops; inputs stay as driven so ignored requests are exercised.
  task automatic wait_fill(input string tag);
    int cnt = 0;
    int bad = 0;
    while (busy0 && cnt < 100) begin
      tick();
      cnt++;
      if (v0 || v1) bad++;
    end
    idle_inputs();
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd32);
    chk({tag, "_valid_during_fill"}, 32'(bad), 32'd0);
    chk({tag, "_busy1_low"}, 32'(busy1), 32'h0);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [31:0] d);
    wren = 1'b1; be = 4'hF; wraddress = a; data_in = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rden = 1'b1; rdaddress = 5'(a);
      tick();
      chk($sformatf("%s_d0_a%0d", tag, a), dout0, 32'h0);
      chk($sformatf("%s_v0_a%0d", tag, a), 32'(v0), 32'h1);
      if (a > 0) begin
        chk($sformatf("%s_d1_a%0d", tag, a - 1), dout1, 32'h0);
        chk($sformatf("%s_v1_a%0d", tag, a - 1), 32'(v1), 32'h1);
      end
    end
    rden = 1'b0;
    tick();
    chk({tag, "_d1_a31"}, dout1, 32'h0);
    chk({tag, "_v1_a31"}, 32'(v1), 32'h1);
    chk({tag, "_v0_idle"}, 32'(v0), 32'h0);
  endtask

  initial begin
    //            wren be    wa     wd            rden ra     e0d           e0v  e1d           e1v
    vecs[0]  = '{1'b1, 4'hF, 5'd5,  32'hAABBCCDD, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 4'h5, 5'd5,  32'h11223344, 1'b0, 5'd0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd5, 32'hAA22CC44, 1'b1, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 5'd7,  32'h00000000, 1'b0, 5'd0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b1};
    vecs[4]  = '{1'b1, 4'h3, 5'd7,  32'hFFFFFFFF, 1'b1, 5'd7, 32'h00000000, 1'b1, 32'hAA22CC44, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd7, 32'h0000FFFF, 1'b1, 32'h0000FFFF, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b0, 5'd0, 32'h0000FFFF, 1'b0, 32'h0000FFFF, 1'b1};
    vecs[7]  = '{1'b1, 4'hF, 5'd9,  32'h12345678, 1'b1, 5'd5, 32'hAA22CC44, 1'b1, 32'h0000FFFF, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 5'd5,  32'hFFFFFFFF, 1'b1, 5'd9, 32'h12345678, 1'b1, 32'hAA22CC44, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b1, 5'd5, 32'hAA22CC44, 1'b1, 32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b0, 5'd0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 5'd0,  32'h00000000, 1'b0, 5'd0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0};

    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    chk_reset_state("reset");
    reset_n = 1'b1;
    wait_fill("fill_reset");
    sweep_zero("sweep_reset");

    // Byte enables, read-during-write, independent ports, be = 0 no-op.
    for (int i = 0; i < 12; i++) begin
      wren = vecs[i].wren; be = vecs[i].be; wraddress = vecs[i].wa; data_in = vecs[i].wd;
      rden = vecs[i].rden; rdaddress = vecs[i].ra;
      tick();
      chk($sformatf("vec%0d_d0", i), dout0, vecs[i].e0d);
      chk($sformatf("vec%0d_v0", i), 32'(v0), 32'(vecs[i].e0v));
      chk($sformatf("vec%0d_d1", i), dout1, vecs[i].e1d);
      chk($sformatf("vec%0d_v1", i), 32'(v1), 32'(vecs[i].e1v));
    end
    idle_inputs();

    // Streaming reads: u1 shows them one edge later than u0.
    for (int k = 1; k <= 4; k++) write_word(5'(k), 32'(k * 16));
    for (int k = 0; k < 6; k++) begin
      rden = (k < 4); rdaddress = 5'(k + 1);
      tick();
      chk($sformatf("stream%0d_v0", k), 32'(v0), 32'(k < 4));
      chk($sformatf("stream%0d_d0", k), dout0, 32'(((k + 1) < 4 ? (k + 1) : 4) * 16));
      chk($sformatf("stream%0d_v1", k), 32'(v1), 32'(k >= 1 && k <= 4));
      chk($sformatf("stream%0d_d1", k), dout1, (k == 0) ? 32'hAA22CC44 : 32'((k < 4 ? k : 4) * 16));
    end
    rden = 1'b0;

    // clear with concurrent write/read; a read already in u1's pipeline completes.
    write_word(5'd3, 32'h77);
    rden = 1'b1; rdaddress = 5'd4;
    tick();
    chk("pre_clear_d0", dout0, 32'h40);
    clear = 1'b1; wren = 1'b1; be = 4'hF; wraddress = 5'd3; data_in = 32'h55; rdaddress = 5'd3;
    tick();
    clear = 1'b0;
    chk("clear_v0", 32'(v0), 32'h0);
    chk("clear_d0", dout0, 32'h40);
    chk("clear_v1", 32'(v1), 32'h1);
    chk("clear_d1", dout1, 32'h40);
    chk("clear_busy0", 32'(busy0), 32'h1);
    wait_fill("fill_clear");
    rden = 1'b1; rdaddress = 5'd3;
    tick();
    rden = 1'b0;
    chk("after_clear_a3_d0", dout0, 32'h0);
    chk("after_clear_a3_v0", 32'(v0), 32'h1);
    tick();
    chk("after_clear_a3_d1", dout1, 32'h0);
    sweep_zero("sweep_clear");

    // Reset in the middle of a fill restarts it from address 0.
    for (int a = 0; a < 32; a++) write_word(5'(a), 32'hC0DE0000 | 32'(a));
    rden = 1'b1; rdaddress = 5'd31;
    tick();
    rden = 1'b0;
    tick();
    chk("prefill_d0", dout0, 32'hC0DE001F);
    chk("prefill_d1", dout1, 32'hC0DE001F);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (20) tick();
    chk("midfill_busy0", 32'(busy0), 32'h1);
    reset_n = 1'b0;
    tick();
    chk_reset_state("midfill_reset");
    reset_n = 1'b1;
    wait_fill("fill_midreset");
    sweep_zero("sweep_midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
